// File: rtl/comms_pkg.sv
// comms_pkg: shared state types and serial line levels for the comms link
package comms_pkg;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/comms_rx.sv
// comms_rx: input synchronizer and frame receiver sampling each bit at its centre
module comms_rx
    import comms_pkg::*;
#(
    parameter int P_CLKS_PER_BIT = 10,
    parameter int P_NUM_BITS     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_input,
    output logic                  rx_valid,
    output logic [P_NUM_BITS-3:0] rx_data
);
    localparam int D  = P_NUM_BITS - 2;
    localparam int CW = $clog2(P_CLKS_PER_BIT + 1);
    localparam int BW = $clog2(P_NUM_BITS + 1);
    localparam logic [CW-1:0] HALF_END = CW'(P_CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(D - 1);
    rx_state_t     state;
    logic          sync_a;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a   <= LINE_IDLE;
            rx_s     <= LINE_IDLE;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            sync_a   <= rx_input;
            rx_s     <= sync_a;
            rx_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_s == START_BIT) state <= RX_START;
                end
                // a start bit that is gone by mid-bit is treated as a glitch
                RX_START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                RX_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        rx_data <= {rx_s, rx_data[D-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= RX_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                RX_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt      <= '0;
                        rx_valid <= (rx_s == STOP_BIT);
                        state    <= RX_IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/comms_tx.sv
// comms_tx: frame transmitter with a registered serial output
module comms_tx
    import comms_pkg::*;
#(
    parameter int P_CLKS_PER_BIT = 10,
    parameter int P_NUM_BITS     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [P_NUM_BITS-3:0] data,
    output logic                  accept,
    output logic                  tx_output
);
    localparam int D  = P_NUM_BITS - 2;
    localparam int CW = $clog2(P_CLKS_PER_BIT + 1);
    localparam int BW = $clog2(P_NUM_BITS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(D - 1);
    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [D-1:0]  sh;
    logic          bit_done;
    assign bit_done = (cnt == BIT_END);
    // chaining straight out of the stop bit keeps back-to-back frames gapless
    assign accept = start && (state == TX_IDLE || (state == TX_STOP && bit_done));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= TX_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            tx_output <= LINE_IDLE;
        end else begin
            cnt <= (state == TX_IDLE || bit_done) ? '0 : cnt + 1'b1;
            if (accept) begin
                state     <= TX_START;
                sh        <= data;
                tx_output <= START_BIT;
            end else begin
                case (state)
                    TX_START: if (bit_done) begin
                        state     <= TX_DATA;
                        bit_cnt   <= '0;
                        tx_output <= sh[0];
                    end
                    TX_DATA: if (bit_done) begin
                        sh        <= sh >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        state     <= (bit_cnt == LAST_BIT) ? TX_STOP : TX_DATA;
                        tx_output <= (bit_cnt == LAST_BIT) ? STOP_BIT : sh[1];
                    end
                    TX_STOP: if (bit_done) state <= TX_IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_comms.sv
// uart_comms: serial endpoint echoing every validly received word back out
module uart_comms
    import comms_pkg::*;
#(
    parameter int P_CLKS_PER_BIT        = 10,
    parameter int P_NUM_BITS_TO_SEND    = 10,
    parameter int P_NUM_BITS_TO_RECEIVE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_input,
    output logic tx_output
);
    localparam int D = P_NUM_BITS_TO_SEND - 2;
    logic         rx_valid;
    logic [D-1:0] rx_data;
    logic [D-1:0] hold;
    logic         pending;
    logic         accept;
    comms_rx #(
        .P_CLKS_PER_BIT(P_CLKS_PER_BIT),
        .P_NUM_BITS    (P_NUM_BITS_TO_RECEIVE)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_input(rx_input),
        .rx_valid(rx_valid),
        .rx_data (rx_data)
    );
    // a newer word replaces one the transmitter has not yet taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold    <= '0;
            pending <= 1'b0;
        end else begin
            if (rx_valid) hold <= rx_data;
            pending <= rx_valid | (pending & ~accept);
        end
    end
    comms_tx #(
        .P_CLKS_PER_BIT(P_CLKS_PER_BIT),
        .P_NUM_BITS    (P_NUM_BITS_TO_SEND)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (pending),
        .data     (hold),
        .accept   (accept),
        .tx_output(tx_output)
    );
endmodule

// File: tb/tb_uart_comms.sv
// tb_uart_comms: drives serial frames into the echo endpoint and checks the echoed frames
module tb_uart_comms;
    localparam int P = 10;
    localparam int N = 10;
    localparam int D = N - 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_input = 1'b1;
    logic tx_output;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    uart_comms #(.P_CLKS_PER_BIT(P), .P_NUM_BITS_TO_SEND(N), .P_NUM_BITS_TO_RECEIVE(N)) dut (
        .clk(clk), .rst(rst), .rx_input(rx_input), .tx_output(tx_output)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // line monitor: captures each frame on tx_output sample by sample
    logic [D-1:0] got_q[$];
    bit exact_q[$];
    int low_cnt = 0;
    int fall_cyc = 0;
    initial begin
        int pos;
        logic [N*P-1:0] buf_s;
        pos = 0;
        buf_s = '0;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) pos = 0;
            else begin
                if (tx_output == 1'b0) low_cnt++;
                if (pos == 0 && tx_output == 1'b0) begin
                    fall_cyc = cyc;
                    buf_s[0] = 1'b0;
                    pos = 1;
                end else if (pos > 0) begin
                    buf_s[pos] = tx_output;
                    pos++;
                    if (pos == N * P) begin
                        bit ok;
                        logic [D-1:0] w;
                        logic lvl;
                        ok = 1'b1;
                        w = '0;
                        for (int b = 0; b < N; b++) begin
                            lvl = (b == 0) ? 1'b0 : (b == N - 1) ? 1'b1 : buf_s[b*P + P/2];
                            if (b > 0 && b < N - 1) w[b-1] = lvl;
                            for (int s = 0; s < P; s++) if (buf_s[b*P + s] !== lvl) ok = 1'b0;
                        end
                        got_q.push_back(w);
                        exact_q.push_back(ok);
                        pos = 0;
                    end
                end
            end
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask
    task automatic send_bit(input logic b);
        rx_input = b;
        repeat (P) @(posedge clk);
        #1;
    endtask
    int start_cyc;
    task automatic send_frame(input logic [D-1:0] d, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < D; i++) send_bit(d[i]);
        send_bit(stop);
        rx_input = 1'b1;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    typedef struct packed {
        logic [7:0] data;
        logic       stop;
        logic [1:0] frames;
        logic [7:0] word;
    } vec_t;
    vec_t vecs[5];
    logic [D-1:0] exp_q[$];
    initial begin
        int base, low0, waited;
        logic [D-1:0] d;
        logic stp;
        vecs[0] = '{8'h83, 1'b1, 2'd1, 8'h83};
        vecs[1] = '{8'h00, 1'b1, 2'd1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 2'd1, 8'hFF};
        vecs[3] = '{8'h55, 1'b0, 2'd0, 8'h00};
        vecs[4] = '{8'hA5, 1'b1, 2'd1, 8'hA5};
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx_output, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        low0 = low_cnt;
        idle(100);
        check("reset_idle_lows", low_cnt - low0, 0);
        for (int i = 0; i < 5; i++) begin
            base = got_q.size();
            send_frame(vecs[i].data, vecs[i].stop);
            idle(150);
            check($sformatf("vec%0d_frames", i), got_q.size() - base, vecs[i].frames);
            if (got_q.size() > base) begin
                check($sformatf("vec%0d_word", i), got_q[base], vecs[i].word);
                check($sformatf("vec%0d_exact", i), exact_q[base], 1);
                check_rng($sformatf("vec%0d_latency", i), fall_cyc - start_cyc, 98, 102);
            end
        end
        base = got_q.size();
        low0 = low_cnt;
        rx_input = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_input = 1'b1;
        idle(200);
        check("glitch_lows", low_cnt - low0, 0);
        check("glitch_frames", got_q.size() - base, 0);
        base = got_q.size();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(250);
        check("b2b_frames", got_q.size() - base, 2);
        if (got_q.size() - base == 2) begin
            check("b2b_first", got_q[base], 8'h12);
            check("b2b_second", got_q[base+1], 8'h34);
            check("b2b_exact", exact_q[base] & exact_q[base+1], 1);
        end
        base = got_q.size();
        send_frame(8'h3C, 1'b1);
        waited = 0;
        while (tx_output !== 1'b0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("mid_rst_tx_started", tx_output, 1'b0);
        idle(30);
        #2 rst = 1'b0;
        #1 check("mid_rst_tx_immediate", tx_output, 1'b1);
        idle(5);
        rst = 1'b1;
        low0 = low_cnt;
        idle(300);
        check("mid_rst_residual_lows", low_cnt - low0, 0);
        check("mid_rst_frames", got_q.size() - base, 0);
        base = got_q.size();
        for (int i = 0; i < 16; i++) begin
            d = D'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            send_frame(d, stp);
            if (stp) exp_q.push_back(d);
            idle(stp ? $urandom_range(0, 15) : 2 * P + $urandom_range(0, 10));
        end
        idle(300);
        check("rand_count", got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            check($sformatf("rand%0d_word", i), got_q[base+i], exp_q[i]);
            check($sformatf("rand%0d_exact", i), exact_q[base+i], 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
